// File: rtl/wb_pkg.sv
// Shared types and constants for the writeback port arbiter.
//   REG_ADDR_W / REG_DATA_W : register-file address and data widths
//   late_entry_t            : one late-queue slot {live, addr, data}
//   reg_onehot()            : register address to 32-bit one-hot mask
package wb_pkg;

  localparam int REG_ADDR_W = 5;
  localparam int REG_DATA_W = 32;

  typedef struct packed {
    logic                  live;
    logic [REG_ADDR_W-1:0] addr;
    logic [REG_DATA_W-1:0] data;
  } late_entry_t;

  function automatic logic [31:0] reg_onehot(input logic [REG_ADDR_W-1:0] a);
    return 32'(1) << a;
  endfunction

endpackage

// File: rtl/wb_port_arbiter_late_queue.sv
// In-order circular queue of late results with a two-entry head view.
// Ports:
//   clk, reset        : clock, asynchronous active-high reset
//   flush             : synchronous clear (count and pointers to zero)
//   push, push_addr/data : enqueue one entry (caller gates with full/flush)
//   kill_en_n/addr_n  : live pipeline writes this cycle; matching entries die
//   pop_cnt           : 0..2 entries removed from the head this cycle
//   head_0, head_1    : two oldest entries, with this cycle's kill applied
//   avail             : bit k set when head_k holds a valid entry
//   full              : count == DEPTH (registered state only)
//   q_busy            : registers targeted by live queued entries
module late_queue
  import wb_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  flush,
  input  logic                  push,
  input  logic [REG_ADDR_W-1:0] push_addr,
  input  logic [REG_DATA_W-1:0] push_data,
  input  logic                  kill_en_1,
  input  logic [REG_ADDR_W-1:0] kill_addr_1,
  input  logic                  kill_en_2,
  input  logic [REG_ADDR_W-1:0] kill_addr_2,
  input  logic [1:0]            pop_cnt,
  output late_entry_t           head_0,
  output late_entry_t           head_1,
  output logic [1:0]            avail,
  output logic                  full,
  output logic [31:0]           q_busy
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  late_entry_t   mem [DEPTH];
  logic [AW-1:0] head;
  logic [AW-1:0] tail;
  logic [CW-1:0] count;
  logic [AW-1:0] head_nx;

  // A same-cycle live pipeline write to the same register supersedes the
  // late result, since every late result is older than the pipeline write.
  function automatic logic hit(input logic [REG_ADDR_W-1:0] a);
    return (kill_en_1 && (kill_addr_1 == a)) || (kill_en_2 && (kill_addr_2 == a));
  endfunction

  assign head_nx = head + AW'(1);
  assign full    = (count == CW'(DEPTH));
  assign avail   = {(count > CW'(1)), (count != '0)};

  always_comb begin
    head_0      = mem[head];
    head_0.live = mem[head].live && !hit(mem[head].addr);
    head_1      = mem[head_nx];
    head_1.live = mem[head_nx].live && !hit(mem[head_nx].addr);
  end

  // Only occupied slots contribute; stale data in free slots is ignored.
  always_comb begin
    logic [AW-1:0] offs;
    q_busy = '0;
    for (int i = 0; i < DEPTH; i++) begin
      offs = AW'(i) - head;
      if ((CW'(offs) < count) && mem[i].live)
        q_busy = q_busy | reg_onehot(mem[i].addr);
    end
  end

  // ---- stage p0 -> p1: queue control state ----
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else if (flush) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      head  <= head + AW'(pop_cnt);
      tail  <= tail + AW'(push);
      count <= count + CW'(push) - CW'(pop_cnt);
    end
  end

  // ---- stage p0 -> p1: queue storage ----
  // Killed entries are marked dead in place; they still pop in order later.
  // An entry killed as it arrives is stored dead, as is address 0.
  always_ff @(posedge clk) begin
    for (int i = 0; i < DEPTH; i++)
      if (hit(mem[i].addr)) mem[i].live <= 1'b0;
    if (push) begin
      mem[tail].live <= (push_addr != '0) && !hit(push_addr);
      mem[tail].addr <= push_addr;
      mem[tail].data <= push_data;
    end
  end

endmodule

// File: rtl/wb_port_arbiter.sv
// Shares the two register-file write ports between the two pipeline
// writeback slots and a queue of late results (mul/div, load returns).
// Ports:
//   clk, reset                 : clock, asynchronous active-high reset
//   wb_en_n/addr_n/data_n      : pipeline slot n write request (slot 2 younger)
//   late_valid/addr/data       : late result offer; late_ready accepts it
//   flush                      : synchronous clear of the late queue
//   reg_w_en_n/addr_n/data_n   : registered register-file write port n
//   q_busy                     : registers targeted by live queued results
module wb_port_arbiter
  import wb_pkg::*;
#(
  parameter int LQ_DEPTH = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        wb_en_1,
  input  logic [4:0]  wb_addr_1,
  input  logic [31:0] wb_data_1,
  input  logic        wb_en_2,
  input  logic [4:0]  wb_addr_2,
  input  logic [31:0] wb_data_2,
  input  logic        late_valid,
  input  logic [4:0]  late_addr,
  input  logic [31:0] late_data,
  output logic        late_ready,
  input  logic        flush,
  output logic        reg_w_en_1,
  output logic [4:0]  reg_w_addr_1,
  output logic [31:0] reg_w_data_1,
  output logic        reg_w_en_2,
  output logic [4:0]  reg_w_addr_2,
  output logic [31:0] reg_w_data_2,
  output logic [31:0] q_busy
);

  logic        live_1, live_2;
  logic        accept;
  logic        q_full;
  logic [1:0]  avail;
  logic [1:0]  pop_cnt;
  late_entry_t head_0, head_1;
  late_entry_t heads [2];

  logic        d1_en, d2_en;
  logic [4:0]  d1_addr, d2_addr;
  logic [31:0] d1_data, d2_data;
  logic        f1, f2, go;

  logic        w_en_1_p0, w_en_2_p0;
  logic [4:0]  w_addr_1_p0, w_addr_2_p0;
  logic [31:0] w_data_1_p0, w_data_2_p0;
  logic        w_en_1_p1, w_en_2_p1;
  logic [4:0]  w_addr_1_p1, w_addr_2_p1;
  logic [31:0] w_data_1_p1, w_data_2_p1;

  assign live_1     = wb_en_1 && (wb_addr_1 != '0);
  assign live_2     = wb_en_2 && (wb_addr_2 != '0);
  assign late_ready = !q_full;
  assign accept     = late_valid && late_ready && !flush;

  late_queue #(.DEPTH(LQ_DEPTH)) u_lq (
    .clk         (clk),
    .reset       (reset),
    .flush       (flush),
    .push        (accept),
    .push_addr   (late_addr),
    .push_data   (late_data),
    .kill_en_1   (live_1),
    .kill_addr_1 (wb_addr_1),
    .kill_en_2   (live_2),
    .kill_addr_2 (wb_addr_2),
    .pop_cnt     (pop_cnt),
    .head_0      (head_0),
    .head_1      (head_1),
    .avail       (avail),
    .full        (q_full),
    .q_busy      (q_busy)
  );

  assign heads[0] = head_0;
  assign heads[1] = head_1;

  // Walk the two oldest entries in order. Dead entries pop for free; a live
  // entry takes the lowest free port, so the older result lands on the
  // lower port and port 2's priority keeps write order. The first live entry
  // that finds no port stops draining. A flushed queue drains nothing.
  always_comb begin
    f1      = !live_1;
    f2      = !live_2;
    go      = !flush;
    pop_cnt = 2'd0;
    d1_en   = 1'b0;
    d1_addr = '0;
    d1_data = '0;
    d2_en   = 1'b0;
    d2_addr = '0;
    d2_data = '0;
    for (int k = 0; k < 2; k++) begin
      if (go && avail[k]) begin
        if (!heads[k].live) begin
          pop_cnt = pop_cnt + 2'd1;
        end else if (f1) begin
          d1_en   = 1'b1;
          d1_addr = heads[k].addr;
          d1_data = heads[k].data;
          f1      = 1'b0;
          pop_cnt = pop_cnt + 2'd1;
        end else if (f2) begin
          d2_en   = 1'b1;
          d2_addr = heads[k].addr;
          d2_data = heads[k].data;
          f2      = 1'b0;
          pop_cnt = pop_cnt + 2'd1;
        end else begin
          go = 1'b0;
        end
      end else begin
        go = 1'b0;
      end
    end
  end

  // Pipeline writes own their port; otherwise the port carries a drain.
  always_comb begin
    w_en_1_p0   = live_1 || d1_en;
    w_addr_1_p0 = live_1 ? wb_addr_1 : d1_addr;
    w_data_1_p0 = live_1 ? wb_data_1 : d1_data;
    w_en_2_p0   = live_2 || d2_en;
    w_addr_2_p0 = live_2 ? wb_addr_2 : d2_addr;
    w_data_2_p0 = live_2 ? wb_data_2 : d2_data;
  end

  // ---- stage p0 -> p1: register-file port registers ----
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      w_en_1_p1   <= 1'b0;
      w_addr_1_p1 <= '0;
      w_data_1_p1 <= '0;
      w_en_2_p1   <= 1'b0;
      w_addr_2_p1 <= '0;
      w_data_2_p1 <= '0;
    end else begin
      w_en_1_p1   <= w_en_1_p0;
      w_addr_1_p1 <= w_addr_1_p0;
      w_data_1_p1 <= w_data_1_p0;
      w_en_2_p1   <= w_en_2_p0;
      w_addr_2_p1 <= w_addr_2_p0;
      w_data_2_p1 <= w_data_2_p0;
    end
  end

  assign reg_w_en_1   = w_en_1_p1;
  assign reg_w_addr_1 = w_addr_1_p1;
  assign reg_w_data_1 = w_data_1_p1;
  assign reg_w_en_2   = w_en_2_p1;
  assign reg_w_addr_2 = w_addr_2_p1;
  assign reg_w_data_2 = w_data_2_p1;

endmodule

// File: tb/tb_wb_port_arbiter.sv
module tb_wb_port_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        wb_en_1, wb_en_2;
  logic [4:0]  wb_addr_1, wb_addr_2;
  logic [31:0] wb_data_1, wb_data_2;
  logic        late_valid;
  logic [4:0]  late_addr;
  logic [31:0] late_data;
  logic        late_ready;
  logic        flush;
  logic        reg_w_en_1, reg_w_en_2;
  logic [4:0]  reg_w_addr_1, reg_w_addr_2;
  logic [31:0] reg_w_data_1, reg_w_data_2;
  logic [31:0] q_busy;

  int vectors    = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  wb_port_arbiter #(.LQ_DEPTH(4)) dut (
    .clk          (clk),
    .reset        (reset),
    .wb_en_1      (wb_en_1),
    .wb_addr_1    (wb_addr_1),
    .wb_data_1    (wb_data_1),
    .wb_en_2      (wb_en_2),
    .wb_addr_2    (wb_addr_2),
    .wb_data_2    (wb_data_2),
    .late_valid   (late_valid),
    .late_addr    (late_addr),
    .late_data    (late_data),
    .late_ready   (late_ready),
    .flush        (flush),
    .reg_w_en_1   (reg_w_en_1),
    .reg_w_addr_1 (reg_w_addr_1),
    .reg_w_data_1 (reg_w_data_1),
    .reg_w_en_2   (reg_w_en_2),
    .reg_w_addr_2 (reg_w_addr_2),
    .reg_w_data_2 (reg_w_data_2),
    .q_busy       (q_busy)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    wb_en_1 = 0; wb_addr_1 = 0; wb_data_1 = 0;
    wb_en_2 = 0; wb_addr_2 = 0; wb_data_2 = 0;
    late_valid = 0; late_addr = 0; late_data = 0;
    flush = 0;
  endtask

  task automatic pipe(input logic e1, input logic [4:0] a1, input logic [31:0] d1,
                      input logic e2, input logic [4:0] a2, input logic [31:0] d2);
    wb_en_1 = e1; wb_addr_1 = a1; wb_data_1 = d1;
    wb_en_2 = e2; wb_addr_2 = a2; wb_data_2 = d2;
  endtask

  task automatic late(input logic v, input logic [4:0] a, input logic [31:0] d);
    late_valid = v; late_addr = a; late_data = d;
  endtask

  task automatic test_reset();
    vectors++;
    if ({reg_w_en_1, reg_w_addr_1, reg_w_data_1, reg_w_en_2, reg_w_addr_2, reg_w_data_2} !== 76'd0) begin
      miscompares++;
      $display("FAIL reset_ports: got %h want 0", {reg_w_en_1, reg_w_addr_1, reg_w_data_1, reg_w_en_2, reg_w_addr_2, reg_w_data_2});
    end
    vectors++;
    if ({late_ready, q_busy} !== {1'b1, 32'h0}) begin
      miscompares++;
      $display("FAIL reset_queue: got ready=%b busy=%h want ready=1 busy=0", late_ready, q_busy);
    end
    reset = 0;
    step();
    vectors++;
    if ({reg_w_en_1, reg_w_en_2, late_ready} !== 3'b001) begin
      miscompares++;
      $display("FAIL reset_release: got %b want 001", {reg_w_en_1, reg_w_en_2, late_ready});
    end
  endtask

  task automatic test_passthrough();
    pipe(1, 5'd5, 32'hA, 1, 5'd5, 32'hB);
    step();
    idle();
    vectors++;
    if ({reg_w_en_1, reg_w_addr_1, reg_w_data_1} !== {1'b1, 5'd5, 32'hA}) begin
      miscompares++;
      $display("FAIL pass_p1: got %h want %h", {reg_w_en_1, reg_w_addr_1, reg_w_data_1}, {1'b1, 5'd5, 32'hA});
    end
    vectors++;
    if ({reg_w_en_2, reg_w_addr_2, reg_w_data_2} !== {1'b1, 5'd5, 32'hB}) begin
      miscompares++;
      $display("FAIL pass_p2: got %h want %h", {reg_w_en_2, reg_w_addr_2, reg_w_data_2}, {1'b1, 5'd5, 32'hB});
    end
    // Address 0 on a slot is not a live write.
    pipe(1, 5'd0, 32'hC, 0, 5'd0, 32'h0);
    step();
    idle();
    vectors++;
    if ({reg_w_en_1, reg_w_en_2} !== 2'b00) begin
      miscompares++;
      $display("FAIL pass_r0: got %b want 00", {reg_w_en_1, reg_w_en_2});
    end
  endtask

  task automatic test_drain();
    pipe(1, 5'd1, 32'h1, 1, 5'd2, 32'h2);
    late(1, 5'd7, 32'h11);
    step();
    late(1, 5'd8, 32'h22);
    step();
    idle();
    vectors++;
    if (q_busy !== 32'h0000_0180) begin
      miscompares++;
      $display("FAIL drain_busy_held: got %h want 00000180", q_busy);
    end
    vectors++;
    if ({reg_w_en_1, reg_w_addr_1, reg_w_en_2, reg_w_addr_2} !== {1'b1, 5'd1, 1'b1, 5'd2}) begin
      miscompares++;
      $display("FAIL drain_pipe_own: got %h want %h", {reg_w_en_1, reg_w_addr_1, reg_w_en_2, reg_w_addr_2}, {1'b1, 5'd1, 1'b1, 5'd2});
    end
    step();
    vectors++;
    if ({reg_w_en_1, reg_w_addr_1, reg_w_data_1} !== {1'b1, 5'd7, 32'h11}) begin
      miscompares++;
      $display("FAIL drain_p1: got %h want %h", {reg_w_en_1, reg_w_addr_1, reg_w_data_1}, {1'b1, 5'd7, 32'h11});
    end
    vectors++;
    if ({reg_w_en_2, reg_w_addr_2, reg_w_data_2} !== {1'b1, 5'd8, 32'h22}) begin
      miscompares++;
      $display("FAIL drain_p2: got %h want %h", {reg_w_en_2, reg_w_addr_2, reg_w_data_2}, {1'b1, 5'd8, 32'h22});
    end
    vectors++;
    if (q_busy !== 32'h0) begin
      miscompares++;
      $display("FAIL drain_busy_clr: got %h want 0", q_busy);
    end
    step();
    vectors++;
    if ({reg_w_en_1, reg_w_en_2} !== 2'b00) begin
      miscompares++;
      $display("FAIL drain_quiet: got %b want 00", {reg_w_en_1, reg_w_en_2});
    end
  endtask

  task automatic test_port_sharing();
    pipe(1, 5'd1, 32'h1, 1, 5'd2, 32'h2);
    late(1, 5'd9, 32'h33);
    step();
    idle();
    pipe(1, 5'd3, 32'h3, 0, 5'd0, 32'h0);
    step();
    idle();
    vectors++;
    if ({reg_w_en_1, reg_w_addr_1, reg_w_data_1} !== {1'b1, 5'd3, 32'h3}) begin
      miscompares++;
      $display("FAIL share_p1: got %h want %h", {reg_w_en_1, reg_w_addr_1, reg_w_data_1}, {1'b1, 5'd3, 32'h3});
    end
    vectors++;
    if ({reg_w_en_2, reg_w_addr_2, reg_w_data_2} !== {1'b1, 5'd9, 32'h33}) begin
      miscompares++;
      $display("FAIL share_p2: got %h want %h", {reg_w_en_2, reg_w_addr_2, reg_w_data_2}, {1'b1, 5'd9, 32'h33});
    end
  endtask

  task automatic test_kill();
    pipe(1, 5'd1, 32'h1, 1, 5'd2, 32'h2);
    late(1, 5'd4, 32'h99);
    step();
    idle();
    vectors++;
    if (q_busy !== 32'h0000_0010) begin
      miscompares++;
      $display("FAIL kill_busy_set: got %h want 00000010", q_busy);
    end
    pipe(0, 5'd0, 32'h0, 1, 5'd4, 32'h44);
    step();
    idle();
    vectors++;
    if ({reg_w_en_1, reg_w_en_2, reg_w_addr_2, reg_w_data_2} !== {1'b0, 1'b1, 5'd4, 32'h44}) begin
      miscompares++;
      $display("FAIL kill_write: got %h want %h", {reg_w_en_1, reg_w_en_2, reg_w_addr_2, reg_w_data_2}, {1'b0, 1'b1, 5'd4, 32'h44});
    end
    vectors++;
    if (q_busy !== 32'h0) begin
      miscompares++;
      $display("FAIL kill_busy_clr: got %h want 0", q_busy);
    end
    // Incoming entry killed by a same-cycle pipeline write, plus an r0 entry.
    pipe(1, 5'd6, 32'h66, 0, 5'd0, 32'h0);
    late(1, 5'd6, 32'h77);
    step();
    idle();
    late(1, 5'd0, 32'h55);
    step();
    idle();
    vectors++;
    if (q_busy !== 32'h0) begin
      miscompares++;
      $display("FAIL kill_dead_busy: got %h want 0", q_busy);
    end
    step();
    step();
    vectors++;
    if ({reg_w_en_1, reg_w_en_2, late_ready} !== 3'b001) begin
      miscompares++;
      $display("FAIL kill_no_stale: got %b want 001", {reg_w_en_1, reg_w_en_2, late_ready});
    end
  endtask

  task automatic test_full_flush();
    logic [3:0] ready_seen;
    ready_seen = '0;
    pipe(1, 5'd1, 32'h1, 1, 5'd2, 32'h2);
    for (int i = 0; i < 4; i++) begin
      late(1, 5'(10 + i), 32'(32'h100 + i));
      step();
      ready_seen[i] = late_ready;
    end
    vectors++;
    if (ready_seen !== 4'b0111) begin
      miscompares++;
      $display("FAIL full_ready_seq: got %b want 0111", ready_seen);
    end
    late(1, 5'd14, 32'h104);
    step();
    vectors++;
    if ({late_ready, q_busy} !== {1'b0, 32'h0000_3C00}) begin
      miscompares++;
      $display("FAIL full_hold: got ready=%b busy=%h want ready=0 busy=00003c00", late_ready, q_busy);
    end
    flush = 1;
    late(1, 5'd15, 32'h105);
    step();
    idle();
    vectors++;
    if ({late_ready, q_busy} !== {1'b1, 32'h0}) begin
      miscompares++;
      $display("FAIL flush_state: got ready=%b busy=%h want ready=1 busy=0", late_ready, q_busy);
    end
    vectors++;
    if ({reg_w_en_1, reg_w_addr_1, reg_w_en_2, reg_w_addr_2} !== {1'b1, 5'd1, 1'b1, 5'd2}) begin
      miscompares++;
      $display("FAIL flush_pipe: got %h want %h", {reg_w_en_1, reg_w_addr_1, reg_w_en_2, reg_w_addr_2}, {1'b1, 5'd1, 1'b1, 5'd2});
    end
    for (int i = 0; i < 3; i++) begin
      step();
      vectors++;
      if ({reg_w_en_1, reg_w_en_2} !== 2'b00) begin
        miscompares++;
        $display("FAIL flush_no_late[%0d]: got %b want 00", i, {reg_w_en_1, reg_w_en_2});
      end
    end
  endtask

  task automatic test_reset_mid();
    pipe(1, 5'd1, 32'h1, 1, 5'd2, 32'h2);
    for (int i = 0; i < 3; i++) begin
      late(1, 5'(20 + i), 32'(32'h200 + i));
      step();
    end
    idle();
    vectors++;
    if (q_busy !== 32'h0070_0000) begin
      miscompares++;
      $display("FAIL rmid_queued: got %h want 00700000", q_busy);
    end
    reset = 1;
    #1;
    vectors++;
    if ({reg_w_en_1, reg_w_addr_1, reg_w_data_1, reg_w_en_2, reg_w_addr_2, reg_w_data_2} !== 76'd0) begin
      miscompares++;
      $display("FAIL rmid_ports: got %h want 0", {reg_w_en_1, reg_w_addr_1, reg_w_data_1, reg_w_en_2, reg_w_addr_2, reg_w_data_2});
    end
    vectors++;
    if ({late_ready, q_busy} !== {1'b1, 32'h0}) begin
      miscompares++;
      $display("FAIL rmid_queue: got ready=%b busy=%h want ready=1 busy=0", late_ready, q_busy);
    end
    step();
    reset = 0;
    for (int i = 0; i < 3; i++) begin
      step();
      vectors++;
      if ({reg_w_en_1, reg_w_en_2, q_busy} !== {2'b00, 32'h0}) begin
        miscompares++;
        $display("FAIL rmid_no_stale[%0d]: got en=%b busy=%h want en=00 busy=0", i, {reg_w_en_1, reg_w_en_2}, q_busy);
      end
    end
  endtask

  initial begin
    idle();
    reset = 1;
    repeat (2) @(posedge clk);
    #1;
    test_reset();
    test_passthrough();
    test_drain();
    test_port_sharing();
    test_kill();
    test_full_flush();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
